// File: rtl/bcd_add_seq_if.sv
// ----------------------------------------------------------------------------
// bcd_add_seq_if
// Bundles the request/result signals of the sequential BCD adder.
//   Start : request a new addition (master -> slave)
//   A, B  : packed BCD operands, digit 0 in bits [3:0] (master -> slave)
//   Busy  : adder is stepping through digits (slave -> master)
//   Done  : one-cycle pulse, Sum/Err valid (slave -> master)
//   Sum   : BCD result, top nibble is the final carry (slave -> master)
//   Err   : last accepted operand pair held a nibble > 9 (slave -> master)
// ----------------------------------------------------------------------------
interface bcd_add_seq_if #(
   parameter int DIGITS = 2
);
   logic                    Start;
   logic [4*DIGITS-1:0]     A;
   logic [4*DIGITS-1:0]     B;
   logic                    Busy;
   logic                    Done;
   logic [4*(DIGITS+1)-1:0] Sum;
   logic                    Err;

   modport master (
      output Start, A, B,
      input  Busy, Done, Sum, Err
   );

   modport slave (
      input  Start, A, B,
      output Busy, Done, Sum, Err
   );
endinterface

// File: rtl/bcd_add_seq.sv
// ----------------------------------------------------------------------------
// bcd_add_seq
// Digit-serial BCD adder: one shared 1-digit BCD adder is reused once per
// digit, ones digit first. Invalid operands (any nibble > 9) skip the add
// and report Err with a zero Sum.
// Ports:
//   CLOCK_50 : system clock, rising edge
//   Reset_n  : asynchronous active-low reset
//   bus      : bcd_add_seq_if slave (Start, A, B in; Busy, Done, Sum, Err out)
// ----------------------------------------------------------------------------
module bcd_add_seq #(
   parameter int DIGITS = 2
) (
   input  logic         CLOCK_50,
   input  logic         Reset_n,
   bcd_add_seq_if.slave bus
);
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                  state_reg;
   state_t                  state_next;
   logic [4*DIGITS-1:0]     a_reg;
   logic [4*DIGITS-1:0]     b_reg;
   logic [IW-1:0]           idx_reg;
   logic                    carry_reg;
   logic                    err_reg;
   logic [4*(DIGITS+1)-1:0] sum_reg;

   logic [DIGITS-1:0]       bad_nib;
   logic                    in_err;
   logic                    accept;
   logic                    last_digit;
   logic                    busy_c;
   logic                    done_c;

   logic [3:0]              a_dig;
   logic [3:0]              b_dig;
   logic [4:0]              dig_sum;
   logic                    dig_cout;
   logic [3:0]              dig_out;

   // Operand validity is judged on the values being latched this edge.
   generate
      for (genvar gi = 0; gi < DIGITS; gi++) begin : g_chk
         assign bad_nib[gi] = (bus.A[4*gi +: 4] > 4'd9) || (bus.B[4*gi +: 4] > 4'd9);
      end
   endgenerate

   assign in_err     = |bad_nib;
   assign accept     = (state_reg == IDLE) && bus.Start;
   assign last_digit = (idx_reg == IW'(DIGITS - 1));

   // Shared 1-digit BCD adder. For s in 10..19, (s + 6) mod 16 == s - 10,
   // so the corrected digit comes from the low nibble plus 6.
   assign a_dig    = a_reg[{idx_reg, 2'b00} +: 4];
   assign b_dig    = b_reg[{idx_reg, 2'b00} +: 4];
   assign dig_sum  = {1'b0, a_dig} + {1'b0, b_dig} + {4'b0000, carry_reg};
   assign dig_cout = (dig_sum > 5'd9);
   assign dig_out  = dig_cout ? (dig_sum[3:0] + 4'd6) : dig_sum[3:0];

   // State register
   always_ff @(posedge CLOCK_50 or negedge Reset_n) begin
      if (!Reset_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (bus.Start) begin
               state_next = in_err ? DONE : ADD;
            end
         end
         ADD: begin
            if (last_digit) begin
               state_next = DONE;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      busy_c = 1'b0;
      done_c = 1'b0;
      case (state_reg)
         ADD:     busy_c = 1'b1;
         DONE:    done_c = 1'b1;
         default: ;
      endcase
   end

   // Datapath: operand capture, digit index, carry, error flag and result.
   always_ff @(posedge CLOCK_50 or negedge Reset_n) begin
      if (!Reset_n) begin
         a_reg     <= '0;
         b_reg     <= '0;
         idx_reg   <= '0;
         carry_reg <= 1'b0;
         err_reg   <= 1'b0;
         sum_reg   <= '0;
      end else if (accept) begin
         a_reg     <= bus.A;
         b_reg     <= bus.B;
         idx_reg   <= '0;
         carry_reg <= 1'b0;
         err_reg   <= in_err;
         sum_reg   <= '0;
      end else if (state_reg == ADD) begin
         carry_reg <= dig_cout;
         for (int i = 0; i < DIGITS; i++) begin
            if (idx_reg == IW'(i)) begin
               sum_reg[4*i +: 4] <= dig_out;
            end
         end
         if (last_digit) begin
            // Index parks on the last digit so it never leaves 0..DIGITS-1.
            sum_reg[4*DIGITS +: 4] <= {3'b000, dig_cout};
         end else begin
            idx_reg <= idx_reg + 1'b1;
         end
      end
   end

   assign bus.Busy = busy_c;
   assign bus.Done = done_c;
   assign bus.Sum  = sum_reg;
   assign bus.Err  = err_reg;

endmodule
